// File: rtl/videobox_affine_coef_bank.sv
`default_nettype none
// ============================================================================
// videobox_affine_coef_bank : double-buffered affine coefficient store with an
// Avalon-MM host port and a pipeline read port. Optional copy-back engine is
// enabled by defining AFFINE_COEF_COPYBACK_EN.
// Revision: 1.0
// ============================================================================
module videobox_affine_coef_bank #(
  parameter int DATA_W    = 32,
  parameter int NUM_COEF  = 8,
  parameter int ADDR_W    = $clog2(NUM_COEF + 2),
  parameter int PX_ADDR_W = $clog2(NUM_COEF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 chipselect,
  input  logic                 read,
  input  logic                 write,
  input  logic [DATA_W/8-1:0]  byteenable,
  input  logic [DATA_W-1:0]    writedata,
  output logic [DATA_W-1:0]    readdata,
  output logic                 readdatavalid,
  output logic                 waitrequest,
  input  logic                 sof,
  input  logic                 px_rd,
  input  logic [PX_ADDR_W-1:0] px_addr,
  output logic [DATA_W-1:0]    px_coef,
  output logic                 px_valid,
  output logic                 swap_irq
);

  localparam int                 BE_W        = DATA_W / 8;
  localparam logic [ADDR_W-1:0]  CTRL_ADDR   = ADDR_W'(NUM_COEF);
  localparam logic [ADDR_W-1:0]  STATUS_ADDR = ADDR_W'(NUM_COEF + 1);
  localparam logic [PX_ADDR_W:0] PX_LIMIT    = (PX_ADDR_W + 1)'(NUM_COEF);

  logic [DATA_W-1:0]    bank_q [2][NUM_COEF];
  logic                 bank_sel_q, bank_sel_d;
  logic                 pending_q, pending_d;
  logic [15:0]          swap_cnt_q, swap_cnt_d;
  logic [DATA_W-1:0]    readdata_q, readdata_d;
  logic [DATA_W-1:0]    px_coef_q, px_coef_d;
  logic                 readdatavalid_q, px_valid_q, swap_irq_q;

  logic                 w_copy_busy;
  logic                 w_copy_wr;
  logic [PX_ADDR_W-1:0] w_copy_idx;
  logic                 w_rd_acc, w_wr_acc, w_swap, w_shadow;
  logic                 w_host_coef;
  logic [PX_ADDR_W-1:0] w_host_idx;

  // A swap cycle stalls the host so shadow writes never race the bank flip.
  assign waitrequest = chipselect & (read | write) & ((sof & pending_q) | w_copy_busy);
  assign w_rd_acc    = chipselect & read  & ~waitrequest;
  assign w_wr_acc    = chipselect & write & ~waitrequest;
  assign w_swap      = sof & pending_q;
  assign w_shadow    = ~bank_sel_q;
  assign w_host_coef = (address < CTRL_ADDR);
  assign w_host_idx  = address[PX_ADDR_W-1:0];

`ifdef AFFINE_COEF_COPYBACK_EN
  localparam logic [PX_ADDR_W-1:0] LAST_IDX = PX_ADDR_W'(NUM_COEF - 1);

  logic                 copy_busy_q, copy_busy_d;
  logic [PX_ADDR_W-1:0] copy_idx_q, copy_idx_d;

  always_comb begin
    copy_busy_d = copy_busy_q;
    copy_idx_d  = copy_idx_q;
    if (w_swap) begin
      copy_busy_d = 1'b1;
      copy_idx_d  = '0;
    end else if (copy_busy_q) begin
      if (copy_idx_q == LAST_IDX) begin
        copy_busy_d = 1'b0;
        copy_idx_d  = '0;
      end else begin
        copy_idx_d = copy_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      copy_busy_q <= 1'b0;
      copy_idx_q  <= '0;
    end else begin
      copy_busy_q <= copy_busy_d;
      copy_idx_q  <= copy_idx_d;
    end
  end

  assign w_copy_busy = copy_busy_q;
  assign w_copy_wr   = copy_busy_q;
  assign w_copy_idx  = copy_idx_q;
`else
  assign w_copy_busy = 1'b0;
  assign w_copy_wr   = 1'b0;
  assign w_copy_idx  = '0;
`endif

  always_comb begin
    bank_sel_d = bank_sel_q;
    pending_d  = pending_q;
    swap_cnt_d = swap_cnt_q;
    if (w_wr_acc && (address == CTRL_ADDR) && writedata[0]) begin
      pending_d = 1'b1;
    end
    if (w_wr_acc && (address == STATUS_ADDR)) begin
      swap_cnt_d = '0;
    end
    // Swap decision uses the pre-write pending value.
    if (w_swap) begin
      bank_sel_d = ~bank_sel_q;
      pending_d  = 1'b0;
      swap_cnt_d = swap_cnt_q + 16'd1;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (w_rd_acc) begin
      if (w_host_coef) begin
        readdata_d = bank_q[w_shadow][w_host_idx];
      end else if (address == CTRL_ADDR) begin
        readdata_d = DATA_W'({w_copy_busy, bank_sel_q, pending_q});
      end else if (address == STATUS_ADDR) begin
        readdata_d = DATA_W'(swap_cnt_q);
      end else begin
        readdata_d = '0;
      end
    end
  end

  always_comb begin
    px_coef_d = px_coef_q;
    if (px_rd) begin
      px_coef_d = ({1'b0, px_addr} < PX_LIMIT) ? bank_q[bank_sel_q][px_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_sel_q      <= 1'b0;
      pending_q       <= 1'b0;
      swap_cnt_q      <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      px_coef_q       <= '0;
      px_valid_q      <= 1'b0;
      swap_irq_q      <= 1'b0;
    end else begin
      bank_sel_q      <= bank_sel_d;
      pending_q       <= pending_d;
      swap_cnt_q      <= swap_cnt_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= w_rd_acc;
      px_coef_q       <= px_coef_d;
      px_valid_q      <= px_rd;
      swap_irq_q      <= w_swap;
    end
  end

  // Host writes and copy-back never coincide: copy_busy stalls the host.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      if (w_wr_acc && w_host_coef) begin
        for (int k = 0; k < BE_W; k++) begin
          if (byteenable[k]) begin
            bank_q[w_shadow][w_host_idx][k*8 +: 8] <= writedata[k*8 +: 8];
          end
        end
      end
      if (w_copy_wr) begin
        bank_q[w_shadow][w_copy_idx] <= bank_q[bank_sel_q][w_copy_idx];
      end
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = readdatavalid_q;
  assign px_coef       = px_coef_q;
  assign px_valid      = px_valid_q;
  assign swap_irq      = swap_irq_q;

endmodule
`default_nettype wire
